// File: rtl/uart_tx_arbiter_pkg.sv
// Shared constants for the UART TX arbiter: FSM encodings, grant index width and byte width.
package uart_tx_arbiter_pkg;

  localparam int unsigned GRANT_W = 3;
  localparam int unsigned BYTE_W  = 8;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_XFER = 1'b1;

endpackage

// File: rtl/rr_priority_pick.sv
// Round-robin pick: rotate the request vector so rr_ptr is bit 0, priority-encode, then unrotate.
module rr_priority_pick
  import uart_tx_arbiter_pkg::*;
#(
  parameter int unsigned N_REQ = 4
) (
  input  logic [N_REQ-1:0]   req,
  input  logic [GRANT_W-1:0] rr_ptr,
  output logic [GRANT_W-1:0] idx,
  output logic               found
);

  logic [N_REQ-1:0]   rot;
  logic [GRANT_W-1:0] off;
  logic [GRANT_W:0]   sum;

  always_comb begin
    rot   = N_REQ'({req, req} >> rr_ptr);
    found = 1'b0;
    off   = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (!found && rot[i]) begin
        found = 1'b1;
        off   = GRANT_W'(i);
      end
    end
    // rr_ptr and off are both below N_REQ, so one conditional subtract wraps the sum
    sum = {1'b0, rr_ptr} + {1'b0, off};
    if (sum >= (GRANT_W + 1)'(N_REQ)) begin
      sum = sum - (GRANT_W + 1)'(N_REQ);
    end
    idx = sum[GRANT_W-1:0];
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-granular round-robin arbiter sharing one byte-wide UART TX channel between N_REQ requesters,
// with a watchdog that reclaims the channel from an owner that stops sending mid-packet.
module uart_tx_arbiter
  import uart_tx_arbiter_pkg::*;
#(
  parameter int unsigned N_REQ       = 4,
  parameter int unsigned TIMEOUT_CYC = 1024,
  parameter int unsigned CNT_W       = 16
) (
  input  logic                    sys_clk,
  input  logic                    reset,
  input  logic [N_REQ-1:0]        req_valid,
  input  logic [BYTE_W*N_REQ-1:0] req_data,
  input  logic [N_REQ-1:0]        req_last,
  output logic [N_REQ-1:0]        req_ready,
  output logic                    tx_valid,
  output logic [BYTE_W-1:0]       tx_data,
  input  logic                    tx_ready,
  output logic [GRANT_W-1:0]      grant_id,
  output logic                    busy,
  output logic                    timeout_evt
);

  localparam logic             WDOG_EN  = (TIMEOUT_CYC != 0);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT_CYC == 0) ? 0 : TIMEOUT_CYC - 1);
  localparam logic [GRANT_W-1:0] LAST_IDX = GRANT_W'(N_REQ - 1);

  logic [0:0]         state_q, state_d;
  logic [GRANT_W-1:0] grant_q, grant_d;
  logic [GRANT_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               busy_q, busy_d;
  logic               evt_q, evt_d;

  logic               own_valid;
  logic               own_last;
  logic [BYTE_W-1:0]  own_data;
  logic               in_xfer;
  logic               beat;
  logic [GRANT_W-1:0] next_ptr;
  logic [GRANT_W-1:0] pick_idx;
  logic               pick_found;

  rr_priority_pick #(
    .N_REQ (N_REQ)
  ) u_pick (
    .req    (req_valid),
    .rr_ptr (rr_ptr_q),
    .idx    (pick_idx),
    .found  (pick_found)
  );

  // Select the current owner's request lane.
  always_comb begin
    own_valid = 1'b0;
    own_last  = 1'b0;
    own_data  = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (grant_q == GRANT_W'(i)) begin
        own_valid = req_valid[i];
        own_last  = req_last[i];
        own_data  = req_data[i*BYTE_W +: BYTE_W];
      end
    end
  end

  assign in_xfer   = (state_q == ST_XFER);
  assign beat      = in_xfer && own_valid && tx_ready;
  assign next_ptr  = (grant_q == LAST_IDX) ? '0 : grant_q + GRANT_W'(1);

  // Zero-latency pass-through from the owner; nothing leaks out while idle.
  assign tx_valid  = in_xfer && own_valid;
  assign tx_data   = in_xfer ? own_data : '0;
  assign req_ready = (in_xfer && tx_ready) ? (N_REQ'(1) << grant_q) : '0;

  assign grant_id    = grant_q;
  assign busy        = busy_q;
  assign timeout_evt = evt_q;

  // Next-state: grant at packet boundaries, release on last beat or watchdog expiry.
  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    rr_ptr_d = rr_ptr_q;
    cnt_d    = cnt_q;
    evt_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (pick_found) begin
          state_d = ST_XFER;
          grant_d = pick_idx;
          cnt_d   = '0;
        end
      end
      ST_XFER: begin
        if (beat) begin
          cnt_d = '0;
          if (own_last) begin
            state_d  = ST_IDLE;
            rr_ptr_d = next_ptr;
          end
        end else if (WDOG_EN && !own_valid) begin
          // Only owner silence counts; back-pressure with valid held never does.
          if (cnt_q == CNT_LAST) begin
            evt_d    = 1'b1;
            state_d  = ST_IDLE;
            rr_ptr_d = next_ptr;
            cnt_d    = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d == ST_XFER);
  end

  always_ff @(posedge sys_clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      grant_q  <= '0;
      rr_ptr_q <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      evt_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      rr_ptr_q <= rr_ptr_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      evt_q    <= evt_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: queued requester models drive packets, a monitor checks every tx beat.
module tb_uart_tx_arbiter;

  localparam int N  = 4;
  localparam int TO = 8;

  logic          sys_clk = 1'b0;
  logic          reset;
  logic [N-1:0]  req_valid;
  logic [8*N-1:0] req_data;
  logic [N-1:0]  req_last;
  logic [N-1:0]  req_ready;
  logic          tx_valid;
  logic [7:0]    tx_data;
  logic          tx_ready;
  logic [2:0]    grant_id;
  logic          busy;
  logic          timeout_evt;

  uart_tx_arbiter #(
    .N_REQ       (N),
    .TIMEOUT_CYC (TO),
    .CNT_W       (16)
  ) dut (
    .sys_clk     (sys_clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_data    (req_data),
    .req_last    (req_last),
    .req_ready   (req_ready),
    .tx_valid    (tx_valid),
    .tx_data     (tx_data),
    .tx_ready    (tx_ready),
    .grant_id    (grant_id),
    .busy        (busy),
    .timeout_evt (timeout_evt)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct {
    logic [7:0] data;
    logic       last;
    int         gap;
  } ent_t;

  typedef struct {
    logic [7:0] data;
    logic [2:0] gid;
    int         delta;
  } exp_t;

  ent_t rq [N][$];
  exp_t sb [$];

  int checks    = 0;
  int errors    = 0;
  int cyc       = 0;
  int prev_beat = -1000;
  int beats     = 0;
  int evt_count = 0;
  int evt_gap   = -1;
  logic [N-1:0] took = '0;
  exp_t mon_e;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_req(input int i, input logic [7:0] d, input logic l, input int gap);
    ent_t e;
    e.data = d; e.last = l; e.gap = gap;
    rq[i].push_back(e);
  endtask

  task automatic push_exp(input logic [7:0] d, input logic [2:0] g, input int delta);
    exp_t e;
    e.data = d; e.gid = g; e.delta = delta;
    sb.push_back(e);
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #2;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset     = 1'b0;
    prev_beat = -1000;
    evt_count = 0;
    evt_gap   = -1;
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while (sb.size() != 0 && n < 400) begin
      tick();
      n++;
    end
    check(name, sb.size(), 0);
    repeat (4) tick();
  endtask

  task automatic wait_beats(input int target);
    int n = 0;
    while (beats < target && n < 200) begin
      tick();
      n++;
    end
    check("wait_beats", 32'(beats >= target), 1);
  endtask

  initial begin : cycle_counter
    forever begin
      @(posedge sys_clk);
      cyc++;
    end
  end

  // Requester models: hold the queue head until accepted, optional idle gap before each byte.
  initial begin : driver
    forever begin
      @(posedge sys_clk);
      #1;
      for (int i = 0; i < N; i++) begin
        if (took[i] && rq[i].size() != 0) void'(rq[i].pop_front());
        if (rq[i].size() != 0) begin
          if (rq[i][0].gap > 0) begin
            ent_t e;
            e = rq[i][0];
            e.gap = e.gap - 1;
            rq[i][0] = e;
            req_valid[i] = 1'b0;
          end else begin
            req_valid[i]          = 1'b1;
            req_data[i*8 +: 8]    = rq[i][0].data;
            req_last[i]           = rq[i][0].last;
          end
        end else begin
          req_valid[i] = 1'b0;
          req_last[i]  = 1'b0;
        end
      end
      took = '0;
    end
  end

  // Monitor: every accepted tx byte must match the scoreboard head.
  initial begin : monitor
    forever begin
      @(negedge sys_clk);
      took = req_valid & req_ready;
      if (timeout_evt) begin
        evt_count++;
        evt_gap = cyc - prev_beat;
      end
      if (tx_valid && tx_ready) begin
        beats++;
        check("req_ready_onehot", 32'(req_ready), 32'(4'b0001 << grant_id));
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_beat: actual data 0x%0h grant %0d, expected no beat", tx_data, grant_id);
        end else begin
          mon_e = sb.pop_front();
          check("tx_data", 32'(tx_data), 32'(mon_e.data));
          check("grant_id", 32'(grant_id), 32'(mon_e.gid));
          if (mon_e.delta >= 0) check("beat_spacing", 32'(cyc - prev_beat), 32'(mon_e.delta));
        end
        prev_beat = cyc;
      end
    end
  end

  initial begin : time_limit
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin : stimulus
    int b0;
    reset     = 1'b1;
    req_valid = '0;
    req_data  = '0;
    req_last  = '0;
    tx_ready  = 1'b1;

    // Reset values and an idle bus.
    do_reset();
    check("rst_busy", 32'(busy), 0);
    check("rst_tx_valid", 32'(tx_valid), 0);
    check("rst_tx_data", 32'(tx_data), 0);
    check("rst_req_ready", 32'(req_ready), 0);
    check("rst_grant_id", 32'(grant_id), 0);
    check("rst_timeout_evt", 32'(timeout_evt), 0);
    repeat (20) begin
      tick();
      check("idle_quiet", 32'({busy, tx_valid, req_ready}), 0);
    end

    // Two 3-byte packets, one bubble in between.
    do_reset();
    for (int k = 0; k < 3; k++) begin
      push_req(0, 8'(8'hA0 + k), (k == 2), 0);
      push_req(2, 8'(8'hC0 + k), (k == 2), 0);
    end
    push_exp(8'hA0, 3'd0, -1);
    push_exp(8'hA1, 3'd0, 1);
    push_exp(8'hA2, 3'd0, 1);
    push_exp(8'hC0, 3'd2, 2);
    push_exp(8'hC1, 3'd2, 1);
    push_exp(8'hC2, 3'd2, 1);
    wait_drain("drain_two_packets");
    check("two_packets_no_evt", 32'(evt_count), 0);

    // All requesters streaming 1-byte packets: strict rotation with wrap.
    do_reset();
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < N; i++) begin
        push_req(i, 8'(8'h80 + 16 * k + i), 1'b1, 0);
        push_exp(8'(8'h80 + 16 * k + i), 3'(i), (k == 0 && i == 0) ? -1 : 2);
      end
    end
    wait_drain("drain_rotation");

    // Requester 1 stalls after 0x11; watchdog hands the channel to waiting requester 3.
    do_reset();
    push_req(1, 8'h11, 1'b0, 0);
    push_req(1, 8'h12, 1'b1, 20);
    push_req(3, 8'h33, 1'b1, 0);
    push_exp(8'h11, 3'd1, -1);
    push_exp(8'h33, 3'd3, 10);
    push_exp(8'h12, 3'd1, -1);
    wait_drain("drain_timeout");
    check("timeout_evt_count", 32'(evt_count), 1);
    // Eight silent cycles after the beat, pulse registered on the eighth edge after it.
    check("timeout_evt_timing", 32'(evt_gap), 9);

    // Serializer back-pressure for 50 cycles mid-packet is not a stall.
    do_reset();
    for (int k = 0; k < 4; k++) push_req(2, 8'(8'h50 + k), (k == 3), 0);
    push_exp(8'h50, 3'd2, -1);
    push_exp(8'h51, 3'd2, 1);
    push_exp(8'h52, 3'd2, -1);
    push_exp(8'h53, 3'd2, 1);
    b0 = beats;
    wait_beats(b0 + 2);
    tx_ready = 1'b0;
    repeat (50) begin
      tick();
      check("backpressure_hold", 32'({tx_valid, tx_data, timeout_evt}), 32'({1'b1, 8'h52, 1'b0}));
    end
    tx_ready = 1'b1;
    wait_drain("drain_backpressure");
    check("backpressure_no_evt", 32'(evt_count), 0);

    // Reset mid-packet with rr_ptr at 3; afterwards the lowest pending index wins.
    do_reset();
    push_req(2, 8'h6F, 1'b1, 0);
    for (int k = 0; k < 4; k++) push_req(3, 8'(8'h60 + k), (k == 3), 0);
    push_req(1, 8'h71, 1'b1, 4);
    push_exp(8'h6F, 3'd2, -1);
    push_exp(8'h60, 3'd3, 2);
    push_exp(8'h71, 3'd1, -1);
    push_exp(8'h61, 3'd3, 2);
    push_exp(8'h62, 3'd3, 1);
    push_exp(8'h63, 3'd3, 1);
    b0 = beats;
    wait_beats(b0 + 2);
    tx_ready = 1'b0;
    repeat (8) tick();
    reset = 1'b1;
    tick();
    check("midrst_busy", 32'(busy), 0);
    check("midrst_tx_valid", 32'(tx_valid), 0);
    check("midrst_req_ready", 32'(req_ready), 0);
    check("midrst_grant_id", 32'(grant_id), 0);
    reset    = 1'b0;
    tx_ready = 1'b1;
    wait_drain("drain_mid_reset");
    check("mid_reset_no_evt", 32'(evt_count), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
